// File: rtl/operand_issue_stage_if.sv
// operand_issue_stage_if: bundles the issue, register-file,
// writeback and execute-side signals of the operand issue stage.
interface operand_issue_stage_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_src1;
    logic [2:0]   in_src2;
    logic         in_uses_src1;
    logic         in_uses_src2;
    logic [2:0]   in_dst;
    logic         in_writes_dst;
    logic [7:0]   in_ctrl;
    logic         rf_read_enable;
    logic [2:0]   rf_read_addr1;
    logic [2:0]   rf_read_addr2;
    logic [N-1:0] rf_read_data1;
    logic [N-1:0] rf_read_data2;
    logic         wb_valid;
    logic [2:0]   wb_addr;
    logic [N-1:0] wb_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_op1;
    logic [N-1:0] out_op2;
    logic [2:0]   out_dst;
    logic         out_writes_dst;
    logic [7:0]   out_ctrl;
    logic [7:0]   busy_mask;

    modport master (
        output in_valid, in_src1, in_src2,
        output in_uses_src1, in_uses_src2,
        output in_dst, in_writes_dst, in_ctrl,
        output rf_read_data1, rf_read_data2,
        output wb_valid, wb_addr, wb_data,
        output flush, out_ready,
        input  in_ready, rf_read_enable,
        input  rf_read_addr1, rf_read_addr2,
        input  out_valid, out_op1, out_op2,
        input  out_dst, out_writes_dst, out_ctrl,
        input  busy_mask
    );

    modport slave (
        input  in_valid, in_src1, in_src2,
        input  in_uses_src1, in_uses_src2,
        input  in_dst, in_writes_dst, in_ctrl,
        input  rf_read_data1, rf_read_data2,
        input  wb_valid, wb_addr, wb_data,
        input  flush, out_ready,
        output in_ready, rf_read_enable,
        output rf_read_addr1, rf_read_addr2,
        output out_valid, out_op1, out_op2,
        output out_dst, out_writes_dst, out_ctrl,
        output busy_mask
    );
endinterface

// File: rtl/operand_issue_stage.sv
// operand_issue_stage: scoreboarded operand read and ID/EX buffer.
// Define WB_BYPASS_EN to forward wb_data into same-cycle readers.
module operand_issue_stage #(
    parameter int N = 16
) (
    input logic               clk,
    input logic               rst,
    operand_issue_stage_if.slave bus
);
    logic [7:0]   pending;
    logic [7:0]   pending_nxt;
    logic         out_valid_q;
    logic [N-1:0] op1_q;
    logic [N-1:0] op2_q;
    logic [2:0]   dst_q;
    logic         wd_q;
    logic [7:0]   ctrl_q;

    logic         wb_hit1;
    logic         wb_hit2;
    logic         wb_hitd;
    logic         byp1;
    logic         byp2;
    logic         raw1;
    logic         raw2;
    logic         waw;
    logic         hazard;
    logic         space;
    logic         issue;
    logic [N-1:0] op1_d;
    logic [N-1:0] op2_d;

    assign wb_hit1 = bus.wb_valid & (bus.wb_addr == bus.in_src1);
    assign wb_hit2 = bus.wb_valid & (bus.wb_addr == bus.in_src2);
    assign wb_hitd = bus.wb_valid & (bus.wb_addr == bus.in_dst);

`ifdef WB_BYPASS_EN
    assign byp1  = wb_hit1;
    assign byp2  = wb_hit2;
    assign op1_d = byp1 ? bus.wb_data : bus.rf_read_data1;
    assign op2_d = byp2 ? bus.wb_data : bus.rf_read_data2;
`else
    logic unused_wb;
    assign unused_wb = (^bus.wb_data) ^ wb_hit1 ^ wb_hit2;
    assign byp1  = 1'b0;
    assign byp2  = 1'b0;
    assign op1_d = bus.rf_read_data1;
    assign op2_d = bus.rf_read_data2;
`endif

    assign raw1 = bus.in_uses_src1 & pending[bus.in_src1] & ~byp1;
    assign raw2 = bus.in_uses_src2 & pending[bus.in_src2] & ~byp2;
    assign waw  = bus.in_writes_dst & pending[bus.in_dst] & ~wb_hitd;

    assign hazard = raw1 | raw2 | waw;
    assign space  = ~out_valid_q | bus.out_ready;
    assign issue  = rst & bus.in_valid & space & ~hazard & ~bus.flush;

    assign bus.in_ready       = issue;
    assign bus.rf_read_enable = bus.in_valid;
    assign bus.rf_read_addr1  = bus.in_src1;
    assign bus.rf_read_addr2  = bus.in_src2;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_op1        = op1_q;
    assign bus.out_op2        = op2_q;
    assign bus.out_dst        = dst_q;
    assign bus.out_writes_dst = wd_q;
    assign bus.out_ctrl       = ctrl_q;
    assign bus.busy_mask      = pending;

    // Scoreboard update: wb clear, then issue set, then flush kill.
    always_comb begin
        pending_nxt = pending;
        if (bus.wb_valid)
            pending_nxt[bus.wb_addr] = 1'b0;
        if (issue && bus.in_writes_dst)
            pending_nxt[bus.in_dst] = 1'b1;
        if (bus.flush && out_valid_q && wd_q)
            pending_nxt[dst_q] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    // ID/EX buffer: load on issue, drain on accept or flush, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            dst_q       <= '0;
            wd_q        <= 1'b0;
            ctrl_q      <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (issue) begin
            out_valid_q <= 1'b1;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            dst_q       <= bus.in_dst;
            wd_q        <= bus.in_writes_dst;
            ctrl_q      <= bus.in_ctrl;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
